// File: rtl/memory_stage_pipelined_pkg.sv
// Shared types for the pipelined MEM stage: word-size codes, access classes,
// FSM states and the byte-lane helpers used by the adapter.
package mem_stage_pkg;

    localparam logic [2:0] SZ_BYTE = 3'b001;
    localparam logic [2:0] SZ_HALF = 3'b010;
    localparam logic [2:0] SZ_WORD = 3'b100;

    localparam int NB_CNT = 2;

    typedef logic [2:0]        size_code_t;
    typedef logic [NB_CNT-1:0] lat_cnt_t;

    typedef enum logic [1:0] {
        ACC_BYTE,
        ACC_HALF,
        ACC_WORD
    } acc_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    // Any code other than byte or half behaves as a full word.
    function automatic acc_t decode_size(input size_code_t size);
        case (size)
            SZ_BYTE: decode_size = ACC_BYTE;
            SZ_HALF: decode_size = ACC_HALF;
            default: decode_size = ACC_WORD;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input acc_t acc, input logic [1:0] lane);
        case (acc)
            ACC_BYTE: lane_mask = 4'b0001 << lane;
            ACC_HALF: lane_mask = 4'b0011 << {lane[1], 1'b0};
            default:  lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input acc_t acc, input logic [1:0] lane);
        case (acc)
            ACC_HALF: is_misaligned = lane[0];
            ACC_WORD: is_misaligned = (lane != 2'b00);
            default:  is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_pipelined_if.sv
// Request/response bus between the EX/MEM register (master) and the MEM stage (slave).
interface memory_stage_pipelined_if #(
    parameter int NB           = 32,
    parameter int NB_SIZE_TYPE = 3
);
    logic                    i_req_valid;
    logic                    o_req_ready;
    logic                    i_mem_read;
    logic                    i_mem_write;
    logic                    i_signed;
    logic [NB_SIZE_TYPE-1:0] i_word_size;
    logic [NB-1:0]           i_address;
    logic [NB-1:0]           i_data_to_write;
    logic                    o_rsp_valid;
    logic [NB-1:0]           o_data_memory;
    logic                    o_stall;
    logic                    o_misaligned;

    modport master (
        output i_req_valid, i_mem_read, i_mem_write, i_signed, i_word_size,
               i_address, i_data_to_write,
        input  o_req_ready, o_rsp_valid, o_data_memory, o_stall, o_misaligned
    );

    modport slave (
        input  i_req_valid, i_mem_read, i_mem_write, i_signed, i_word_size,
               i_address, i_data_to_write,
        output o_req_ready, o_rsp_valid, o_data_memory, o_stall, o_misaligned
    );
endinterface

// File: rtl/memory_stage_pipelined_byte_lane_adapter.sv
// Combinational sub-word handling: store-data replication and byte enables, load extract/extend.
// Alignment faults are reported only when MEM_ALIGN_CHECK_EN is defined.
module byte_lane_adapter
    import mem_stage_pkg::*;
#(
    parameter int NB = 32
) (
    input  size_code_t    wr_size,
    input  logic [1:0]    wr_lane,
    input  logic [NB-1:0] wr_data,
    output logic [NB-1:0] wr_data_rep,
    output logic [3:0]    wr_byte_en,
    output logic          wr_misaligned,
    input  size_code_t    rd_size,
    input  logic [1:0]    rd_lane,
    input  logic          rd_signed,
    input  logic [NB-1:0] rd_word,
    output logic [NB-1:0] rd_data,
    output logic          rd_misaligned
);

    acc_t          wr_acc;
    acc_t          rd_acc;
    logic [NB-1:0] byte_shifted;
    logic [NB-1:0] half_shifted;
    logic [NB-1:0] rd_ext;

    assign wr_acc = decode_size(wr_size);
    assign rd_acc = decode_size(rd_size);

`ifdef MEM_ALIGN_CHECK_EN
    assign wr_misaligned = is_misaligned(wr_acc, wr_lane);
    assign rd_misaligned = is_misaligned(rd_acc, rd_lane);
`else
    assign wr_misaligned = 1'b0;
    assign rd_misaligned = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_data_rep = wr_data;
        case (wr_acc)
            ACC_BYTE: wr_data_rep = {4{wr_data[7:0]}};
            ACC_HALF: wr_data_rep = {2{wr_data[15:0]}};
            default:  wr_data_rep = wr_data;
        endcase
        wr_byte_en = wr_misaligned ? 4'b0000 : lane_mask(wr_acc, wr_lane);
    end

    always_comb begin
        byte_shifted = rd_word >> {rd_lane, 3'b000};
        half_shifted = rd_word >> {rd_lane[1], 4'b0000};
        rd_ext       = rd_word;
        case (rd_acc)
            ACC_BYTE: rd_ext = rd_signed ? {{24{byte_shifted[7]}}, byte_shifted[7:0]}
                                         : {24'h0, byte_shifted[7:0]};
            ACC_HALF: rd_ext = rd_signed ? {{16{half_shifted[15]}}, half_shifted[15:0]}
                                         : {16'h0, half_shifted[15:0]};
            default:  rd_ext = rd_word;
        endcase
        rd_data = rd_misaligned ? '0 : rd_ext;
    end

endmodule

// File: rtl/memory_stage_pipelined.sv
// Pipelined data-memory stage: byte-lane RAM, load-latency FSM, response and debug registers.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module memory_stage_pipelined
    import mem_stage_pkg::*;
#(
    parameter int NB           = 32,
    parameter int DEPTH        = 64,
    parameter int NB_SIZE_TYPE = 3,
    parameter int READ_LATENCY = 2
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_step,
    memory_stage_pipelined_if.slave bus,
    input  logic [NB-1:0]           i_debug_address,
    output logic [NB-1:0]           o_data_debug_memory
);

    localparam int NB_IDX = $clog2(DEPTH);

    logic [NB-1:0] mem [DEPTH];

    state_t                  state;
    lat_cnt_t                cnt;
    logic [NB_IDX-1:0]       ld_idx;
    logic [1:0]              ld_lane;
    logic [NB_SIZE_TYPE-1:0] ld_size;
    logic                    ld_signed;

    logic          rsp_valid_q;
    logic [NB-1:0] data_q;
    logic          stall_q;
    logic          misaligned_q;

    logic              accept;
    logic              is_store;
    logic              is_load;
    logic              mem_we;
    logic [NB_IDX-1:0] wr_idx;
    logic [NB-1:0]     wr_data_rep;
    logic [3:0]        wr_byte_en;
    logic              wr_misaligned;
    logic [NB-1:0]     rd_word;
    logic [NB-1:0]     rd_data;
    logic              rd_misaligned;
    logic              unused_addr_bits;

    assign bus.o_req_ready   = (state == IDLE);
    assign bus.o_rsp_valid   = rsp_valid_q;
    assign bus.o_data_memory = data_q;
    assign bus.o_stall       = stall_q;
    assign bus.o_misaligned  = misaligned_q;

    assign accept   = bus.i_req_valid & bus.o_req_ready & i_step;
    assign is_store = bus.i_mem_write;
    assign is_load  = bus.i_mem_read & ~bus.i_mem_write;
    assign mem_we   = accept & is_store & ~i_reset;
    assign wr_idx   = bus.i_address[NB_IDX+1:2];
    assign rd_word  = mem[ld_idx];

    // Address bits above the word index wrap away by design.
    assign unused_addr_bits = &{1'b0, bus.i_address[NB-1:NB_IDX+2],
                                i_debug_address[NB-1:NB_IDX]};

    byte_lane_adapter #(.NB(NB)) u_lane (
        .wr_size       (size_code_t'(bus.i_word_size)),
        .wr_lane       (bus.i_address[1:0]),
        .wr_data       (bus.i_data_to_write),
        .wr_data_rep   (wr_data_rep),
        .wr_byte_en    (wr_byte_en),
        .wr_misaligned (wr_misaligned),
        .rd_size       (size_code_t'(ld_size)),
        .rd_lane       (ld_lane),
        .rd_signed     (ld_signed),
        .rd_word       (rd_word),
        .rd_data       (rd_data),
        .rd_misaligned (rd_misaligned)
    );

    // NOTE: the RAM array has no reset; contents survive i_reset and map onto block RAM.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_byte_en[b]) mem[wr_idx][8*b +: 8] <= wr_data_rep[8*b +: 8];
            end
        end
    end

    // The debug port keeps sampling while the pipeline is frozen by i_step.
    always_ff @(posedge i_clk) begin
        if (i_reset) o_data_debug_memory <= '0;
        else         o_data_debug_memory <= mem[i_debug_address[NB_IDX-1:0]];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            cnt          <= '0;
            rsp_valid_q  <= 1'b0;
            data_q       <= '0;
            stall_q      <= 1'b0;
            misaligned_q <= 1'b0;
            ld_idx       <= '0;
            ld_lane      <= '0;
            ld_size      <= '0;
            ld_signed    <= 1'b0;
        end else if (i_step) begin
            rsp_valid_q  <= 1'b0;
            misaligned_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_load) begin
                            state     <= BUSY;
                            cnt       <= lat_cnt_t'(READ_LATENCY - 1);
                            stall_q   <= 1'b1;
                            ld_idx    <= wr_idx;
                            ld_lane   <= bus.i_address[1:0];
                            ld_size   <= bus.i_word_size;
                            ld_signed <= bus.i_signed;
                        end else begin
                            // Stores and no-op requests answer on the next cycle.
                            rsp_valid_q  <= 1'b1;
                            misaligned_q <= is_store & wr_misaligned;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state        <= RESP;
                        stall_q      <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        data_q       <= rd_data;
                        misaligned_q <= rd_misaligned;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
